// File: rtl/load_unit_pkg.sv
// Shared types and constants for the misaligned load unit.
//   state_e       : load sequencer states
//   SIZE_*        : read_size encodings (log2 of access bytes)
//   access_bytes(): access size in bytes, with oversize requests clamped to one memory word
package load_unit_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReqLow,
    StReqHigh,
    StWait
  } state_e;

  localparam int unsigned SIZE_BYTE  = 0;
  localparam int unsigned SIZE_HALF  = 1;
  localparam int unsigned SIZE_WORD  = 2;
  localparam int unsigned SIZE_DWORD = 3;

  function automatic int unsigned access_bytes(input int unsigned size, input int unsigned off_w);
    return (size > off_w) ? (32'd1 << off_w) : (32'd1 << size);
  endfunction

endpackage

// File: rtl/load_beat_buffer.sv
// Two-entry in-order capture of returned memory words.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : empty the buffer (takes priority over capture)
//   capture      : store data into the next free entry; ignored once both entries are full
//   data         : returned memory word
//   beat0, beat1 : first and second captured words
//   count        : number of captured words, saturating at 2
module load_beat_buffer #(
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    capture,
  input  logic [8*DATA_BYTES-1:0] data,
  output logic [8*DATA_BYTES-1:0] beat0,
  output logic [8*DATA_BYTES-1:0] beat1,
  output logic [1:0]              count
);

  logic [8*DATA_BYTES-1:0] beat0_q, beat1_q;
  logic [1:0]              count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat0_q <= '0;
      beat1_q <= '0;
      count_q <= 2'd0;
    end else if (clear) begin
      beat0_q <= '0;
      beat1_q <= '0;
      count_q <= 2'd0;
    end else if (capture) begin
      if (count_q == 2'd0) begin
        beat0_q <= data;
        count_q <= 2'd1;
      end else if (count_q == 2'd1) begin
        beat1_q <= data;
        count_q <= 2'd2;
      end
    end
  end

  assign beat0 = beat0_q;
  assign beat1 = beat1_q;
  assign count = count_q;

endmodule

// File: rtl/misaligned_load_unit.sv
// Load unit between the pipeline load port and the memory read port. Byte/half/word/dword
// loads at any byte address; accesses crossing a memory word are issued as two beats whose
// returned words are merged, shifted down and zero- or sign-extended.
//   clk, reset_n        : clock, asynchronous active-low reset
//   read_ready/req      : load handshake (accept when both high)
//   read_addr/size/signed : byte address, log2(bytes), sign-extend select
//   read_data/_valid    : result (held until next completion) and one-cycle completion pulse
//   mem_ready           : memory accepts mem_read_req this cycle
//   mem_addr/byte_enable/read_req : word-aligned beat request, held until accepted
//   mem_read_data/_valid: returned words, in order
//   read_fault          : present only when LOAD_UNIT_MISALIGN_FAULT_EN is defined; crossing
//                         accesses then complete immediately with a fault instead of splitting
module misaligned_load_unit
  import load_unit_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned DATA_BYTES = 4,
  localparam int unsigned DW         = 8 * DATA_BYTES,
  localparam int unsigned OFF_W      = $clog2(DATA_BYTES),
  localparam int unsigned SIZE_W     = $clog2(OFF_W + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  read_ready,
  input  logic                  read_req,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [SIZE_W-1:0]     read_size,
  input  logic                  read_signed,
  output logic [DW-1:0]         read_data,
  output logic                  read_data_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_BYTES-1:0] mem_byte_enable,
  output logic                  mem_read_req,
  input  logic [DW-1:0]         mem_read_data,
  input  logic                  mem_read_data_valid
`ifdef LOAD_UNIT_MISALIGN_FAULT_EN
  ,
  output logic                  read_fault
`endif
);

  localparam int unsigned NW = OFF_W + 1;

  state_e                  state_q;
  logic                    ready_q, req_q, rvalid_q, signed_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_BYTES-1:0]   be_q, high_be_q;
  logic [OFF_W-1:0]        off_q;
  logic [NW-1:0]           n_q;
  logic [1:0]              beats_q;
  logic [DW-1:0]           rdata_q;
`ifdef LOAD_UNIT_MISALIGN_FAULT_EN
  logic                    fault_q;
`endif

  // Request decode: byte mask over two consecutive memory words
  logic [OFF_W-1:0]        req_off;
  int unsigned             req_n;
  logic [2*DATA_BYTES-1:0] req_mask;
  logic                    crossing;
  logic                    accept;

  always_comb begin
    req_off = read_addr[OFF_W-1:0];
    req_n   = access_bytes(32'(read_size), OFF_W);
    for (int unsigned i = 0; i < 2 * DATA_BYTES; i++) begin
      req_mask[i] = (i >= 32'(req_off)) && (i < 32'(req_off) + req_n);
    end
  end

  assign crossing = |req_mask[2*DATA_BYTES-1:DATA_BYTES];
  assign accept   = (state_q == StIdle) && ready_q && read_req;

  // Beat capture runs in every busy state, including the cycle a later beat is accepted
  logic [DW-1:0] beat0, beat1;
  logic [1:0]    count;

  load_beat_buffer #(
    .DATA_BYTES(DATA_BYTES)
  ) u_beat_buffer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .capture(mem_read_data_valid && (state_q != StIdle)),
    .data   (mem_read_data),
    .beat0  (beat0),
    .beat1  (beat1),
    .count  (count)
  );

  // Merge, align to byte 0, then extend above the accessed bytes
  logic [DW-1:0] shifted, result;
  logic          sign_bit;

  assign shifted = DW'({beat1, beat0} >> {off_q, 3'b000});

  always_comb begin
    result   = '0;
    sign_bit = 1'b0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (i < 32'(n_q)) begin
        result[8*i +: 8] = shifted[8*i +: 8];
        sign_bit         = signed_q & shifted[8*i+7];
      end
    end
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (i >= 32'(n_q)) result[8*i +: 8] = {8{sign_bit}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ready_q   <= 1'b1;
      req_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      signed_q  <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      high_be_q <= '0;
      off_q     <= '0;
      n_q       <= '0;
      beats_q   <= 2'd0;
      rdata_q   <= '0;
`ifdef LOAD_UNIT_MISALIGN_FAULT_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
`ifdef LOAD_UNIT_MISALIGN_FAULT_EN
      fault_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (!ready_q) begin
            // Completion pulse cycle just ended; reopen for the next load
            ready_q <= 1'b1;
          end else if (read_req) begin
            ready_q   <= 1'b0;
            off_q     <= req_off;
            n_q       <= NW'(req_n);
            signed_q  <= read_signed;
            high_be_q <= req_mask[2*DATA_BYTES-1:DATA_BYTES];
            beats_q   <= crossing ? 2'd2 : 2'd1;
`ifdef LOAD_UNIT_MISALIGN_FAULT_EN
            if (crossing) begin
              fault_q  <= 1'b1;
              rvalid_q <= 1'b1;
            end else begin
              req_q   <= 1'b1;
              addr_q  <= {read_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
              be_q    <= req_mask[DATA_BYTES-1:0];
              state_q <= StReqLow;
            end
`else
            req_q   <= 1'b1;
            addr_q  <= {read_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            be_q    <= req_mask[DATA_BYTES-1:0];
            state_q <= StReqLow;
`endif
          end
        end
        StReqLow: begin
          if (mem_ready) begin
            if (high_be_q == '0) begin
              req_q   <= 1'b0;
              state_q <= StWait;
            end else begin
              addr_q  <= addr_q + ADDR_WIDTH'(DATA_BYTES);
              be_q    <= high_be_q;
              state_q <= StReqHigh;
            end
          end
        end
        StReqHigh: begin
          if (mem_ready) begin
            req_q   <= 1'b0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (count == beats_q) begin
            rdata_q  <= result;
            rvalid_q <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign read_ready      = ready_q;
  assign read_data       = rdata_q;
  assign read_data_valid = rvalid_q;
  assign mem_addr        = addr_q;
  assign mem_byte_enable = be_q;
  assign mem_read_req    = req_q;
`ifdef LOAD_UNIT_MISALIGN_FAULT_EN
  assign read_fault      = fault_q;
`endif

endmodule
